nasti_stream_downsizer: RTL and testbench
=========================================

# nasti_stream_downsizer

Width-reducing stage that sits directly downstream of `nasti_stream_buf`. It accepts wide AXI-stream beats (default 64 bit) and emits them as a sequence of narrow beats (default 16 bit), least-significant slice first. Slices whose `t_keep` bits are all zero (null slices) are dropped. It feeds narrow consumers such as UART/SPI byte engines and debug ports from a buffered 64-bit stream.

## Interface
Parameters:
- `ID_WIDTH`, 1, stream id width (passed through)
- `DEST_WIDTH`, 1, destination width (passed through)
- `USER_WIDTH`, 1, user width (passed through)
- `IN_WIDTH`, 64, `src` data width; multiple of `OUT_WIDTH`
- `OUT_WIDTH`, 16, `dest` data width; multiple of 8
- derived `RATIO = IN_WIDTH/OUT_WIDTH` (≥1), `SW = OUT_WIDTH/8`

Ports:
- `aclk`  in  1  clock; all logic is on the rising edge
- `aresetn`  in  1  reset, asynchronous, active-low
- `src`  `nasti_stream_channel.slave`  `IN_WIDTH`  wide input stream
- `dest`  `nasti_stream_channel.master`  `OUT_WIDTH`  narrow output stream, registered

## Operation
- Holding register: one wide beat (`data`, `strb`, `keep`, `last`, `id`, `dest`, `user`), plus `busy` and a `RATIO`-bit pending-slice mask.
- On accept, pending mask bit i = OR of `keep[i*SW +: SW]`.
- If the accepted beat has all `keep` zero:
  - with `t_last`=1, the mask is forced to slice 0, so a zero-keep last beat is emitted;
  - with `t_last`=0, the beat is dropped and nothing is emitted.
- Emitted slice = lowest set bit of the pending mask.
- Each output beat carries:
  - the data, strb and keep slice of the emitted slice;
  - `id`, `dest` and `user` copied from the holding register;
  - `t_last` = held `last` AND (the emitted slice is the highest set bit of the mask).
- On `dest` fire, the emitted bit is cleared. When the mask becomes empty, `busy` deasserts.
- States: IDLE (`busy`=0) and DRAIN (`busy`=1).
  - IDLE→DRAIN when `src` fires with a non-empty mask.
  - DRAIN→IDLE when the final slice fires and no new beat is accepted.
  - DRAIN→DRAIN when the final slice fires together with a new accept.
- `src.t_ready` = !`busy` OR (`dest` fire on the final pending slice). This is combinational from the registered state and `dest.t_ready`.
- Slice data is never reordered. Slices with partial keep (e.g. keep=2'b01) are emitted unchanged.

## Timing
- Reset values:
  - `dest.t_valid`=0 and `dest.t_last`=0; data, strb, keep, id, dest, user = 0;
  - `busy`=0, mask=0, so `src.t_ready`=1.
- Latency: first narrow beat is valid on the cycle after `src` fires.
- Throughput: one narrow beat per cycle while `dest.t_ready`=1. There are no bubbles between consecutive wide beats, because accept overlaps the final slice.
- `dest.t_valid` stays high, with stable payload, until `dest.t_ready`. The output registers update only on fire, or when loading into an empty output stage.
- A wide beat with k non-null slices takes k cycles of `dest` bandwidth. A zero-keep non-last beat consumes one `src` cycle and produces no output.
- Reset asserted mid-drain:
  - discards the held beat immediately (asynchronously);
  - `dest.t_valid` drops without waiting for a handshake.
- `RATIO`=1 degenerates to a one-entry register slice that still drops null beats.

## Structure
- Shared package `nasti_stream_pkg`: `RATIO`/`SW` derivation functions and the lowest-set/highest-set bit functions over a mask.
- One sub-module: `nasti_stream_slice_sel` (combinational). Input: pending mask. Outputs: emitted index, its one-hot, and an `is_final` flag. It is reused by a future upsizer.
- The top module contains the holding register, mask FSM and output register. The interfaces are instantiated with differing `DATA_WIDTH` by the parent.

## Test plan
- Full keep: data=64'h4444_3333_2222_1111, keep=8'hFF, last=1, `dest.t_ready`=1 → beats 16'h1111, 16'h2222, 16'h3333, 16'h4444 on consecutive cycles; only the 4th has last=1; `src.t_ready` is high on the 4th cycle.
- Sparse keep: keep=8'b0011_0011, last=1 → two beats, 16'h1111 (last=0) then 16'h3333 (last=1, keep=2'b11).
- Null beats:
  - keep=0, last=0 → no output and `src.t_ready` high the next cycle;
  - keep=0, last=1 → one beat with keep=0, last=1.
- Back-pressure: `dest.t_ready` toggled 1,0,0,1,… across 3 back-to-back wide beats → output stable while stalled; exactly 12 narrow beats in order; no loss or duplication.
- Streaming: 100 random wide beats with random keep and `dest.t_ready` at 70% → the scoreboard (reference slicer model) matches data/strb/keep/last/id/dest/user; zero idle cycles when ready is constantly 1.
- Reset mid-drain: `aresetn` low after slice 1 of 4 → `dest.t_valid`=0 and `src.t_ready`=1 during reset; after release, the next beat is emitted from slice 0 with no stale data.

Source files
------------

// File: rtl/nasti_stream_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nasti_stream_pkg : shared width-conversion helpers for stream resizers   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package nasti_stream_pkg;

    localparam int unsigned MAX_RATIO = 64;

    typedef logic [MAX_RATIO-1:0] mask_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } drain_state_t;

    function automatic int unsigned calc_ratio(input int unsigned in_w, input int unsigned out_w);
        return in_w / out_w;
    endfunction

    function automatic int unsigned calc_sw(input int unsigned out_w);
        return out_w / 8;
    endfunction

    // Index vectors stay at least one bit wide so RATIO=1 still elaborates.
    function automatic int unsigned calc_idx_w(input int unsigned ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    function automatic int lowest_set(input mask_t m);
        int r;
        r = 0;
        for (int i = MAX_RATIO - 1; i >= 0; i--) begin
            if (m[i]) r = i;
        end
        return r;
    endfunction

    function automatic int highest_set(input mask_t m);
        int r;
        r = 0;
        for (int i = 0; i < MAX_RATIO; i++) begin
            if (m[i]) r = i;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nasti_stream_slice_sel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nasti_stream_slice_sel : picks the lowest pending slice of a mask        |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module nasti_stream_slice_sel
    import nasti_stream_pkg::*;
#(
    parameter int unsigned RATIO = 4,
    parameter int unsigned IDX_W = calc_idx_w(RATIO)
) (
    input  logic [RATIO-1:0] mask,
    output logic [IDX_W-1:0] idx,
    output logic [RATIO-1:0] onehot,
    output logic             is_final
);

    mask_t w_ext;
    int    w_lo;
    int    w_hi;

    always_comb begin
        w_ext            = '0;
        w_ext[RATIO-1:0] = mask;
        w_lo             = lowest_set(w_ext);
        w_hi             = highest_set(w_ext);
        idx              = IDX_W'(w_lo);
        for (int i = 0; i < RATIO; i++) begin
            onehot[i] = (mask != '0) && (w_lo == i);
        end
        // Final means the emitted slice is also the last one still pending.
        is_final = (mask != '0) && (w_lo == w_hi);
    end

endmodule
`default_nettype wire

// File: rtl/nasti_stream_downsizer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nasti_stream_downsizer : splits wide stream beats into narrow slices     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module nasti_stream_downsizer
    import nasti_stream_pkg::*;
#(
    parameter int unsigned ID_WIDTH   = 1,
    parameter int unsigned DEST_WIDTH = 1,
    parameter int unsigned USER_WIDTH = 1,
    parameter int unsigned IN_WIDTH   = 64,
    parameter int unsigned OUT_WIDTH  = 16
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    src_t_valid,
    output logic                    src_t_ready,
    input  logic [IN_WIDTH-1:0]     src_t_data,
    input  logic [IN_WIDTH/8-1:0]   src_t_strb,
    input  logic [IN_WIDTH/8-1:0]   src_t_keep,
    input  logic                    src_t_last,
    input  logic [ID_WIDTH-1:0]     src_t_id,
    input  logic [DEST_WIDTH-1:0]   src_t_dest,
    input  logic [USER_WIDTH-1:0]   src_t_user,
    output logic                    dest_t_valid,
    input  logic                    dest_t_ready,
    output logic [OUT_WIDTH-1:0]    dest_t_data,
    output logic [OUT_WIDTH/8-1:0]  dest_t_strb,
    output logic [OUT_WIDTH/8-1:0]  dest_t_keep,
    output logic                    dest_t_last,
    output logic [ID_WIDTH-1:0]     dest_t_id,
    output logic [DEST_WIDTH-1:0]   dest_t_dest,
    output logic [USER_WIDTH-1:0]   dest_t_user
);

    localparam int unsigned RATIO = calc_ratio(IN_WIDTH, OUT_WIDTH);
    localparam int unsigned SW    = calc_sw(OUT_WIDTH);
    localparam int unsigned IDX_W = calc_idx_w(RATIO);
    localparam int unsigned IN_SW = IN_WIDTH / 8;

    drain_state_t r_state;
    drain_state_t w_state_nxt;
    logic [RATIO-1:0] r_mask;
    logic [RATIO-1:0] w_mask_nxt;

    logic [IN_WIDTH-1:0]   r_data;
    logic [IN_SW-1:0]      r_strb;
    logic [IN_SW-1:0]      r_keep;
    logic                  r_last;
    logic [ID_WIDTH-1:0]   r_id;
    logic [DEST_WIDTH-1:0] r_dest;
    logic [USER_WIDTH-1:0] r_user;

    logic                  r_out_valid;
    logic [OUT_WIDTH-1:0]  r_out_data;
    logic [SW-1:0]         r_out_strb;
    logic [SW-1:0]         r_out_keep;
    logic                  r_out_last;
    logic [ID_WIDTH-1:0]   r_out_id;
    logic [DEST_WIDTH-1:0] r_out_dest;
    logic [USER_WIDTH-1:0] r_out_user;

    logic             w_dest_fire;
    logic             w_src_ready;
    logic             w_src_fire;
    logic [RATIO-1:0] w_new_mask;
    logic             w_new_nonempty;
    logic [IDX_W-1:0] w_cur_idx;
    logic [RATIO-1:0] w_cur_onehot;
    logic             w_cur_final;
    logic [RATIO-1:0] w_rem_mask;
    logic             w_from_hold;
    logic             w_from_src;
    logic             w_load;
    logic [RATIO-1:0] w_load_mask;
    logic [IDX_W-1:0] w_ld_idx;
    logic [RATIO-1:0] w_ld_onehot;
    logic             w_ld_final;
    logic             w_ld_last;
    logic [IN_WIDTH-1:0] w_ld_data;
    logic [IN_SW-1:0]    w_ld_strb;
    logic [IN_SW-1:0]    w_ld_keep;
    logic                w_unused_sel;

    // Each mask bit marks a slice that carries at least one kept byte.
    always_comb begin
        w_new_mask = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            w_new_mask[i] = |src_t_keep[i*SW +: SW];
        end
        if ((w_new_mask == '0) && src_t_last) begin
            w_new_mask[0] = 1'b1;
        end
    end

    assign w_new_nonempty = (w_new_mask != '0);

    nasti_stream_slice_sel #(
        .RATIO (RATIO),
        .IDX_W (IDX_W)
    ) u_cur_sel (
        .mask     (r_mask),
        .idx      (w_cur_idx),
        .onehot   (w_cur_onehot),
        .is_final (w_cur_final)
    );

    assign w_dest_fire = r_out_valid && dest_t_ready;
    assign w_src_ready = (r_state == ST_IDLE) || (w_dest_fire && w_cur_final);
    assign w_src_fire  = src_t_valid && w_src_ready;
    assign w_rem_mask  = r_mask & ~w_cur_onehot;

    // The next output slice comes from the held beat while it still has
    // pending slices, otherwise from a freshly accepted beat.
    assign w_from_hold = w_dest_fire && !w_cur_final;
    assign w_from_src  = w_src_fire && w_new_nonempty;
    assign w_load      = w_from_hold || w_from_src;
    assign w_load_mask = w_from_hold ? w_rem_mask : w_new_mask;

    nasti_stream_slice_sel #(
        .RATIO (RATIO),
        .IDX_W (IDX_W)
    ) u_load_sel (
        .mask     (w_load_mask),
        .idx      (w_ld_idx),
        .onehot   (w_ld_onehot),
        .is_final (w_ld_final)
    );

    assign w_unused_sel = ^{w_cur_idx, w_ld_onehot};

    assign w_ld_data = w_from_hold ? r_data : src_t_data;
    assign w_ld_strb = w_from_hold ? r_strb : src_t_strb;
    assign w_ld_keep = w_from_hold ? r_keep : src_t_keep;
    assign w_ld_last = (w_from_hold ? r_last : src_t_last) && w_ld_final;

    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        case (r_state)
            ST_IDLE: begin
                if (w_src_fire && w_new_nonempty) begin
                    w_state_nxt = ST_DRAIN;
                    w_mask_nxt  = w_new_mask;
                end
            end
            ST_DRAIN: begin
                if (w_dest_fire) begin
                    if (!w_cur_final) begin
                        w_mask_nxt = w_rem_mask;
                    end else if (w_src_fire && w_new_nonempty) begin
                        w_mask_nxt = w_new_mask;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_mask_nxt  = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_mask_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
            r_mask  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mask  <= w_mask_nxt;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_data <= '0;
            r_strb <= '0;
            r_keep <= '0;
            r_last <= 1'b0;
            r_id   <= '0;
            r_dest <= '0;
            r_user <= '0;
        end else if (w_src_fire) begin
            r_data <= src_t_data;
            r_strb <= src_t_strb;
            r_keep <= src_t_keep;
            r_last <= src_t_last;
            r_id   <= src_t_id;
            r_dest <= src_t_dest;
            r_user <= src_t_user;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_strb  <= '0;
            r_out_keep  <= '0;
            r_out_last  <= 1'b0;
            r_out_id    <= '0;
            r_out_dest  <= '0;
            r_out_user  <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_ld_data[w_ld_idx*OUT_WIDTH +: OUT_WIDTH];
            r_out_strb  <= w_ld_strb[w_ld_idx*SW +: SW];
            r_out_keep  <= w_ld_keep[w_ld_idx*SW +: SW];
            r_out_last  <= w_ld_last;
            r_out_id    <= w_from_hold ? r_id   : src_t_id;
            r_out_dest  <= w_from_hold ? r_dest : src_t_dest;
            r_out_user  <= w_from_hold ? r_user : src_t_user;
        end else if (w_dest_fire) begin
            r_out_valid <= 1'b0;
        end
    end

    assign src_t_ready  = w_src_ready;
    assign dest_t_valid = r_out_valid;
    assign dest_t_data  = r_out_data;
    assign dest_t_strb  = r_out_strb;
    assign dest_t_keep  = r_out_keep;
    assign dest_t_last  = r_out_last;
    assign dest_t_id    = r_out_id;
    assign dest_t_dest  = r_out_dest;
    assign dest_t_user  = r_out_user;

endmodule
`default_nettype wire

// File: tb/tb_nasti_stream_downsizer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_nasti_stream_downsizer : directed and random bench for the downsizer  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_nasti_stream_downsizer;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        src_t_valid = 1'b0;
    logic        src_t_ready;
    logic [63:0] src_t_data = '0;
    logic [7:0]  src_t_strb = '0;
    logic [7:0]  src_t_keep = '0;
    logic        src_t_last = 1'b0;
    logic        src_t_id = 1'b0;
    logic        src_t_dest = 1'b0;
    logic        src_t_user = 1'b0;
    logic        dest_t_valid;
    logic        dest_t_ready = 1'b1;
    logic [15:0] dest_t_data;
    logic [1:0]  dest_t_strb;
    logic [1:0]  dest_t_keep;
    logic        dest_t_last;
    logic        dest_t_id;
    logic        dest_t_dest;
    logic        dest_t_user;

    nasti_stream_downsizer #(
        .ID_WIDTH   (1),
        .DEST_WIDTH (1),
        .USER_WIDTH (1),
        .IN_WIDTH   (64),
        .OUT_WIDTH  (16)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .src_t_valid  (src_t_valid),
        .src_t_ready  (src_t_ready),
        .src_t_data   (src_t_data),
        .src_t_strb   (src_t_strb),
        .src_t_keep   (src_t_keep),
        .src_t_last   (src_t_last),
        .src_t_id     (src_t_id),
        .src_t_dest   (src_t_dest),
        .src_t_user   (src_t_user),
        .dest_t_valid (dest_t_valid),
        .dest_t_ready (dest_t_ready),
        .dest_t_data  (dest_t_data),
        .dest_t_strb  (dest_t_strb),
        .dest_t_keep  (dest_t_keep),
        .dest_t_last  (dest_t_last),
        .dest_t_id    (dest_t_id),
        .dest_t_dest  (dest_t_dest),
        .dest_t_user  (dest_t_user)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  strb;
        logic [1:0]  keep;
        logic        last;
        logic        id;
        logic        dst;
        logic        user;
    } beat_t;

    int    cyc = 0;
    int    n_cmp = 0;
    int    n_bad = 0;
    int    last_acc = 0;
    int    rmode = 0;
    int    rphase = 0;
    beat_t exp_q[$];
    beat_t got_q[$];
    int    got_cyc[$];
    bit    got_sr[$];
    beat_t cur;
    beat_t stall_b;
    bit    stalled = 1'b0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference slicer: every slice with any kept byte becomes one narrow
    // beat, lowest first; an all-null last beat still yields slice 0.
    task automatic model_push(input logic [63:0] d, input logic [7:0] s, input logic [7:0] k,
                              input logic l, input logic id, input logic dst, input logic usr);
        int hi;
        hi = -1;
        for (int i = 0; i < 4; i++) if (k[2*i +: 2] != 2'b00) hi = i;
        if (hi < 0) begin
            if (l) exp_q.push_back({d[15:0], s[1:0], k[1:0], 1'b1, id, dst, usr});
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (k[2*i +: 2] != 2'b00)
                    exp_q.push_back({d[16*i +: 16], s[2*i +: 2], k[2*i +: 2], l && (i == hi), id, dst, usr});
            end
        end
    endtask

    always @(negedge aclk) begin
        if (!aresetn) begin
            exp_q.delete();
            stalled = 1'b0;
        end else begin
            cur = {dest_t_data, dest_t_strb, dest_t_keep, dest_t_last, dest_t_id, dest_t_dest, dest_t_user};
            if (stalled) chk("stall_hold", {39'd0, dest_t_valid, cur}, {39'd0, 1'b1, stall_b});
            if (dest_t_valid && dest_t_ready) begin
                got_q.push_back(cur);
                got_cyc.push_back(cyc);
                got_sr.push_back(src_t_ready);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat: got %h expected none", cur);
                end else begin
                    chk("beat", {40'd0, cur}, {40'd0, exp_q.pop_front()});
                end
            end
            stalled = dest_t_valid && !dest_t_ready;
            stall_b = cur;
            if (src_t_valid && src_t_ready)
                model_push(src_t_data, src_t_strb, src_t_keep, src_t_last, src_t_id, src_t_dest, src_t_user);
        end
    end

    always @(posedge aclk) begin
        #1;
        case (rmode)
            1: begin
                dest_t_ready = (rphase % 3 == 0);
                rphase++;
            end
            2: dest_t_ready = ($urandom_range(99) < 70);
            default: dest_t_ready = 1'b1;
        endcase
    end

    task automatic send(input logic [63:0] d, input logic [7:0] s, input logic [7:0] k,
                        input logic l, input logic id, input logic dst, input logic usr);
        int n;
        bit fired;
        n = 0;
        fired = 1'b0;
        src_t_valid = 1'b1;
        src_t_data  = d;
        src_t_strb  = s;
        src_t_keep  = k;
        src_t_last  = l;
        src_t_id    = id;
        src_t_dest  = dst;
        src_t_user  = usr;
        while (!fired) begin
            @(negedge aclk);
            fired = src_t_ready;
            if (fired) last_acc = cyc;
            @(posedge aclk);
            #1;
            n++;
            if (!fired && n > 200) begin
                n_cmp++;
                n_bad++;
                $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
                break;
            end
        end
    endtask

    task automatic idle_src();
        src_t_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(posedge aclk);
            #2;
            if (exp_q.size() == 0 && !dest_t_valid) done = 1'b1;
        end
        chk("drain", {63'd0, done}, 64'd1);
    endtask

    task automatic clear_log();
        got_q.delete();
        got_cyc.delete();
        got_sr.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        logic [63:0] d;
        logic [7:0]  k;

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_valid", {63'd0, dest_t_valid}, 64'd0);
        chk("rst_last",  {63'd0, dest_t_last}, 64'd0);
        chk("rst_data",  {44'd0, dest_t_data, dest_t_strb, dest_t_keep}, 64'd0);
        chk("rst_ready", {63'd0, src_t_ready}, 64'd1);
        @(posedge aclk);
        #1 aresetn = 1'b1;

        // Full keep
        clear_log();
        send(64'h4444_3333_2222_1111, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1);
        idle_src();
        wait_drain();
        chk("full_count", got_q.size(), 4);
        if (got_q.size() >= 4) begin
            chk("full_d0", got_q[0].data, 16'h1111);
            chk("full_d1", got_q[1].data, 16'h2222);
            chk("full_d2", got_q[2].data, 16'h3333);
            chk("full_d3", got_q[3].data, 16'h4444);
            chk("full_lasts", {got_q[0].last, got_q[1].last, got_q[2].last, got_q[3].last}, 4'b0001);
            chk("full_latency", got_cyc[0], last_acc + 1);
            chk("full_consec", got_cyc[3], last_acc + 4);
            chk("full_sready", {got_sr[0], got_sr[3]}, 2'b01);
            chk("full_side", {got_q[0].id, got_q[0].dst, got_q[0].user}, 3'b101);
        end

        // Sparse keep
        clear_log();
        send(64'h4444_3333_2222_1111, 8'hFF, 8'b0011_0011, 1'b1, 1'b0, 1'b1, 1'b0);
        idle_src();
        wait_drain();
        chk("sparse_count", got_q.size(), 2);
        if (got_q.size() >= 2) begin
            chk("sparse_b0", {got_q[0].data, got_q[0].last}, {16'h1111, 1'b0});
            chk("sparse_b1", {got_q[1].data, got_q[1].keep, got_q[1].last}, {16'h3333, 2'b11, 1'b1});
        end

        // Null beats
        clear_log();
        send(64'hDEAD_BEEF_0000_1234, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_src();
        @(negedge aclk);
        chk("null_valid", {63'd0, dest_t_valid}, 64'd0);
        chk("null_sready", {63'd0, src_t_ready}, 64'd1);
        @(posedge aclk);
        #1;
        chk("null_count", got_q.size(), 0);
        send(64'h0000_0000_0000_ABCD, 8'h03, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
        idle_src();
        wait_drain();
        chk("nlast_count", got_q.size(), 1);
        if (got_q.size() >= 1)
            chk("nlast_beat", {got_q[0].data, got_q[0].keep, got_q[0].last}, {16'hABCD, 2'b00, 1'b1});

        // Back-pressure, 1,0,0 ready pattern
        clear_log();
        rphase = 0;
        rmode = 1;
        send(64'h0004_0003_0002_0001, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        send(64'h0008_0007_0006_0005, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        send(64'h000C_000B_000A_0009, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_src();
        wait_drain();
        rmode = 0;
        chk("bp_count", got_q.size(), 12);
        for (int i = 0; i < got_q.size() && i < 12; i++) chk("bp_order", got_q[i].data, i + 1);

        // Back-to-back with ready held high: no bubbles
        @(posedge aclk);
        #1;
        clear_log();
        send(64'h0104_0103_0102_0101, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        send(64'h0108_0107_0106_0105, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        send(64'h010C_010B_010A_0109, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_src();
        wait_drain();
        chk("b2b_count", got_q.size(), 12);
        if (got_q.size() >= 12) chk("b2b_span", got_cyc[11] - got_cyc[0], 11);

        // Random streaming against the model
        rmode = 2;
        for (int n = 0; n < 100; n++) begin
            d = {$urandom, $urandom};
            case ($urandom_range(9))
                0: k = 8'h00;
                1: k = 8'hFF;
                default: k = 8'($urandom);
            endcase
            send(d, 8'($urandom), k, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(3) == 0) begin
                idle_src();
                @(posedge aclk);
                #1;
            end
        end
        idle_src();
        wait_drain();
        rmode = 0;
        chk("rand_left", exp_q.size(), 0);

        // Reset in the middle of a drain
        @(posedge aclk);
        #1;
        clear_log();
        send(64'h4444_3333_2222_1111, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_src();
        @(negedge aclk);
        chk("mid_first", {47'd0, dest_t_valid, dest_t_data}, {47'd0, 1'b1, 16'h1111});
        @(posedge aclk);
        #1 aresetn = 1'b0;
        #1;
        chk("mid_rst_valid", {63'd0, dest_t_valid}, 64'd0);
        chk("mid_rst_sready", {62'd0, src_t_ready, dest_t_last}, {62'd0, 2'b10});
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        clear_log();
        send(64'h8888_7777_6666_5555, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_src();
        wait_drain();
        chk("post_rst_count", got_q.size(), 4);
        if (got_q.size() >= 4)
            chk("post_rst_data", {got_q[0].data, got_q[1].data, got_q[2].data, got_q[3].data},
                64'h5555_6666_7777_8888);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
